// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared types and defaults for the deserializer word-alignment logic
package serdes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_LOCKED,
    ST_FAILED
  } state_t;

  localparam int WIDTH_DEFAULT = 14;
  localparam logic [13:0] FRAME_PATTERN_14 = 14'h3F80;

endpackage

// File: rtl/serdes_word_match.sv
// rtl/serdes_word_match.sv - one-stage registered compare of a deserialized word against a fixed pattern
module serdes_word_match import serdes_pkg::*; #(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(FRAME_PATTERN_14)
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [WIDTH-1:0] q,
  output logic             match
);

  logic [WIDTH-1:0] qReg;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      qReg <= '0;
    end else begin
      qReg <= q;
    end
  end

  assign match = (qReg == PATTERN);

endmodule

// File: rtl/serdes_bitslip_ctrl.sv
// rtl/serdes_bitslip_ctrl.sv - frame-word alignment FSM driving BITSLIP until the training pattern locks
module serdes_bitslip_ctrl import serdes_pkg::*; #(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(FRAME_PATTERN_14),
  parameter int SETTLE_CYCLES = 4,
  parameter int MATCH_COUNT = 16,
  parameter int MISS_LIMIT = 4,
  parameter int MAX_SLIPS = 14
) (
  input  logic             CLKDIV,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] Q,
  output logic             BITSLIP,
  output logic             BUSY,
  output logic             LOCKED,
  output logic             FAIL,
  output logic [3:0]       SLIP_CNT
);

  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] MISS_LAST = 4'(MISS_LIMIT - 1);
  localparam logic [3:0] SLIP_MAX = 4'(MAX_SLIPS);
  localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_COUNT - 1);

  state_t state;
  logic [3:0] settleCnt;
  logic [3:0] missCnt;
  logic [MW-1:0] matchCnt;
  logic match;

  serdes_word_match #(
    .WIDTH  (WIDTH),
    .PATTERN(PATTERN)
  ) uMatch (
    .clk  (CLKDIV),
    .rstN (RST),
    .q    (Q),
    .match(match)
  );

  always_ff @(posedge CLKDIV) begin
    if (!RST) begin
      state     <= ST_IDLE;
      BITSLIP   <= 1'b0;
      BUSY      <= 1'b0;
      LOCKED    <= 1'b0;
      FAIL      <= 1'b0;
      SLIP_CNT  <= '0;
      settleCnt <= '0;
      missCnt   <= '0;
      matchCnt  <= '0;
    end else begin
      BITSLIP <= 1'b0;
      // START only restarts from a resting state; it is ignored mid-alignment
      if (START && (state == ST_IDLE || state == ST_LOCKED || state == ST_FAILED)) begin
        state     <= ST_SETTLE;
        BUSY      <= 1'b1;
        LOCKED    <= 1'b0;
        FAIL      <= 1'b0;
        SLIP_CNT  <= '0;
        settleCnt <= '0;
        missCnt   <= '0;
        matchCnt  <= '0;
      end else begin
        case (state)
          ST_SETTLE: begin
            if (settleCnt == SETTLE_LAST) begin
              state     <= ST_CHECK;
              settleCnt <= '0;
              matchCnt  <= '0;
            end else begin
              settleCnt <= settleCnt + 4'd1;
            end
          end
          ST_CHECK: begin
            if (match) begin
              if (matchCnt == MATCH_LAST) begin
                state   <= ST_LOCKED;
                BUSY    <= 1'b0;
                LOCKED  <= 1'b1;
                missCnt <= '0;
              end else begin
                matchCnt <= matchCnt + MW'(1);
              end
            end else if (SLIP_CNT >= SLIP_MAX) begin
              state <= ST_FAILED;
              BUSY  <= 1'b0;
              FAIL  <= 1'b1;
            end else begin
              // pulse and count are raised together on entry to SLIP
              state    <= ST_SLIP;
              BITSLIP  <= 1'b1;
              SLIP_CNT <= SLIP_CNT + 4'd1;
            end
          end
          ST_SLIP: begin
            state     <= ST_SETTLE;
            settleCnt <= '0;
          end
          ST_LOCKED: begin
            if (match) begin
              missCnt <= '0;
            end else if (missCnt == MISS_LAST) begin
              state    <= ST_CHECK;
              LOCKED   <= 1'b0;
              BUSY     <= 1'b1;
              SLIP_CNT <= '0;
              missCnt  <= '0;
              matchCnt <= '0;
            end else begin
              missCnt <= missCnt + 4'd1;
            end
          end
          ST_IDLE, ST_FAILED: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serdes_bitslip_ctrl.sv
// tb/tb_serdes_bitslip_ctrl.sv - directed and randomized checks of serdes_bitslip_ctrl against a rotating-deserializer model
module tb_serdes_bitslip_ctrl;

  localparam int SETTLE = 4;
  localparam int MATCH = 16;
  localparam int MISS = 4;
  localparam int MAXS = 14;
  localparam logic [13:0] PAT = 14'h3F80;

  logic CLKDIV = 1'b0;
  logic RST = 1'b0;
  logic START = 1'b0;
  logic [13:0] Q = '0;
  logic BITSLIP, BUSY, LOCKED, FAIL;
  logic [3:0] SLIP_CNT;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulses = 0;
  int lastPulse = -1;
  int spaceErr = 0;
  int dblErr = 0;
  int off = 0;
  int badLeft = 0;
  logic prevBs = 1'b0;
  logic slipPending = 1'b0;
  logic fixedMode = 1'b0;
  logic [13:0] badWord = '0;
  logic [13:0] fixedWord = '0;

  serdes_bitslip_ctrl #(
    .WIDTH(14), .PATTERN(PAT), .SETTLE_CYCLES(SETTLE),
    .MATCH_COUNT(MATCH), .MISS_LIMIT(MISS), .MAX_SLIPS(MAXS)
  ) dut (
    .CLKDIV(CLKDIV), .RST(RST), .START(START), .Q(Q),
    .BITSLIP(BITSLIP), .BUSY(BUSY), .LOCKED(LOCKED), .FAIL(FAIL), .SLIP_CNT(SLIP_CNT)
  );

  always #5 CLKDIV = ~CLKDIV;

  function automatic logic [13:0] rotl(input int n);
    logic [27:0] d;
    d = {PAT, PAT} << n;
    return d[27:14];
  endfunction

  function automatic int lockLat(input int o);
    return SETTLE + MATCH + o * (SETTLE + 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Deserializer model: each BITSLIP pulse undoes one bit of rotation, visible two edges later.
  task automatic step();
    @(posedge CLKDIV);
    #1;
    cyc++;
    if (BITSLIP) begin
      if (lastPulse >= 0 && (cyc - lastPulse) < SETTLE + 1) spaceErr++;
      lastPulse = cyc;
      pulses++;
    end
    if (BITSLIP && prevBs) dblErr++;
    prevBs = BITSLIP;
    if (slipPending) off = (off == 0) ? 13 : off - 1;
    slipPending = BITSLIP;
    if (badLeft > 0) begin
      Q = badWord;
      badLeft--;
    end else if (fixedMode) begin
      Q = fixedWord;
    end else begin
      Q = rotl(off);
    end
  endtask

  task automatic doStart();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (!LOCKED && !FAIL && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic alignRun(input string tag, input int o);
    int p0, c0;
    fixedMode = 1'b0;
    off = o;
    Q = rotl(off);
    p0 = pulses;
    doStart();
    c0 = cyc;
    waitDone(400);
    check({tag, "_locked"}, 32'(LOCKED), 32'd1);
    check({tag, "_slipcnt"}, 32'(SLIP_CNT), 32'(o));
    check({tag, "_pulses"}, 32'(pulses - p0), 32'(o));
    check({tag, "_latency"}, 32'(cyc - c0), 32'(lockLat(o)));
  endtask

  initial begin
    int p0, c0, n, keep;
    logic stayed;

    repeat (3) step();
    check("rst_bitslip", 32'(BITSLIP), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_locked", 32'(LOCKED), 32'd0);
    check("rst_fail", 32'(FAIL), 32'd0);
    check("rst_slipcnt", 32'(SLIP_CNT), 32'd0);
    RST = 1'b1;
    step();

    alignRun("aligned", 0);
    check("aligned_busy", 32'(BUSY), 32'd0);

    alignRun("rot3", 3);
    check("rot3_spacing", 32'(spaceErr), 32'd0);
    check("rot3_single", 32'(dblErr), 32'd0);

    badWord = rotl(1);
    badLeft = 3;
    stayed = 1'b1;
    repeat (10) begin
      step();
      stayed = stayed & LOCKED;
    end
    check("miss3_hold", 32'(stayed), 32'd1);

    badLeft = MISS;
    repeat (MISS + 1) step();
    check("miss4_before", 32'(LOCKED), 32'd1);
    step();
    check("miss4_drop", 32'(LOCKED), 32'd0);
    check("miss4_busy", 32'(BUSY), 32'd1);
    check("miss4_slipcnt", 32'(SLIP_CNT), 32'd0);
    p0 = pulses;
    waitDone(200);
    check("relock", 32'(LOCKED), 32'd1);
    check("relock_noslip", 32'(pulses - p0), 32'd0);

    for (int i = 0; i < 4; i++) alignRun("rand_off", int'($urandom_range(0, 13)));

    fixedMode = 1'b0;
    off = 4;
    Q = rotl(off);
    p0 = pulses;
    doStart();
    c0 = cyc;
    n = 0;
    while (pulses == p0 && n < 100) begin
      step();
      n++;
    end
    repeat (2) step();
    keep = int'(SLIP_CNT);
    START = 1'b1;
    step();
    START = 1'b0;
    check("start_settle_slipcnt", 32'(SLIP_CNT), 32'(keep));
    check("start_settle_busy", 32'(BUSY), 32'd1);
    waitDone(400);
    check("start_settle_lock", 32'(LOCKED), 32'd1);
    check("start_settle_lat", 32'(cyc - c0), 32'(lockLat(4)));

    fixedMode = 1'b1;
    fixedWord = 14'h0000;
    Q = fixedWord;
    p0 = pulses;
    doStart();
    c0 = cyc;
    waitDone(400);
    check("zero_fail", 32'(FAIL), 32'd1);
    check("zero_locked", 32'(LOCKED), 32'd0);
    check("zero_busy", 32'(BUSY), 32'd0);
    check("zero_slipcnt", 32'(SLIP_CNT), 32'(MAXS));
    check("zero_pulses", 32'(pulses - p0), 32'(MAXS));
    check("zero_latency", 32'(cyc - c0), 32'(SETTLE + 1 + MAXS * (SETTLE + 2)));
    repeat (5) step();
    check("fail_sticky", 32'(FAIL), 32'd1);

    fixedMode = 1'b0;
    off = 0;
    Q = rotl(off);
    doStart();
    check("restart_fail_clr", 32'(FAIL), 32'd0);
    check("restart_busy", 32'(BUSY), 32'd1);
    waitDone(400);
    check("restart_lock", 32'(LOCKED), 32'd1);

    fixedMode = 1'b1;
    fixedWord = 14'($urandom_range(0, 16383));
    if (fixedWord == PAT) fixedWord = fixedWord ^ 14'h0001;
    Q = fixedWord;
    p0 = pulses;
    doStart();
    waitDone(400);
    check("randword_fail", 32'(FAIL), 32'd1);
    check("randword_pulses", 32'(pulses - p0), 32'(MAXS));

    fixedMode = 1'b0;
    off = 5;
    Q = rotl(off);
    p0 = pulses;
    doStart();
    n = 0;
    while (pulses < p0 + 2 && n < 200) begin
      step();
      n++;
    end
    step();
    check("abort_busy_before", 32'(BUSY), 32'd1);
    RST = 1'b0;
    step();
    RST = 1'b1;
    check("abort_bitslip", 32'(BITSLIP), 32'd0);
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_locked", 32'(LOCKED), 32'd0);
    check("abort_fail", 32'(FAIL), 32'd0);
    check("abort_slipcnt", 32'(SLIP_CNT), 32'd0);
    p0 = pulses;
    repeat (30) step();
    check("abort_quiet", 32'(pulses - p0), 32'd0);
    check("abort_idle", 32'(BUSY), 32'd0);
    check("final_spacing", 32'(spaceErr), 32'd0);
    check("final_single", 32'(dblErr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
